// File: rtl/mdu_seq.sv
// Iterative RV64M multiply/divide sequencer: shift-add multiplier and restoring
// divider working on operand magnitudes, with sign fix-up on the last iteration.
module mdu_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func3,
  input  logic            is_word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext_half(input logic [XLEN-1:0] v);
    return {{HW{v[HW-1]}}, v[HW-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] fit_word(input logic [XLEN-1:0] v, input logic narrow);
    return narrow ? sext_half(v) : v;
  endfunction

  function automatic logic [XLEN-1:0] ext_op(input logic [XLEN-1:0] v, input logic word,
                                             input logic sgn);
    if (!word) return v;
    return sgn ? sext_half(v) : {{HW{1'b0}}, v[HW-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic            word_eff, sgn1, sgn2, neg1, neg2, div_zero, div_ovf, special;
  logic [XLEN-1:0] ext1, ext2, mag1, mag2, spec_val;

  // Illegal W combos (mulh*) run at full width; only the result is narrowed.
  assign word_eff = is_word & ((func3 == 3'b000) | func3[2]);
  assign sgn1     = func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
  assign sgn2     = func3 inside {3'b000, 3'b001, 3'b100, 3'b110};
  assign ext1     = ext_op(src1, word_eff, sgn1);
  assign ext2     = ext_op(src2, word_eff, sgn2);
  assign neg1     = sgn1 & ext1[XLEN-1];
  assign neg2     = sgn2 & ext2[XLEN-1];
  assign mag1     = neg_if(ext1, neg1);
  assign mag2     = neg_if(ext2, neg2);
  assign div_zero = func3[2] & (ext2 == '0);
  assign div_ovf  = func3[2] & ~func3[0] & (ext1 == (word_eff ? MIN_W : MIN_D)) & (&ext2);
  assign special  = div_zero | div_ovf;
  // The overflow quotient equals the (extended) dividend, which is MIN at N width.
  assign spec_val = div_zero ? (func3[1] ? ext1 : {XLEN{1'b1}})
                             : (func3[1] ? {XLEN{1'b0}} : ext1);

  logic                is_div_p0, sel_p0, narrow_p0, neg_p0;
  logic [2*XLEN-1:0]   prod_p0, mcand_p0;
  logic [XLEN-1:0]     mplier_p0, rem_p0, quo_p0, dvsr_p0;
  logic [2*XLEN-1:0]   prod_nx, prod_fin;
  logic [XLEN:0]       trial;
  logic                q_bit;
  logic [XLEN-1:0]     rem_nx, quo_nx, mul_val, div_val, calc_val;

  assign prod_nx  = prod_p0 + (mplier_p0[0] ? mcand_p0 : {(2*XLEN){1'b0}});
  assign prod_fin = neg_p0 ? -prod_nx : prod_nx;
  assign trial    = {rem_p0, quo_p0[XLEN-1]} - {1'b0, dvsr_p0};
  assign q_bit    = ~trial[XLEN];
  assign rem_nx   = q_bit ? trial[XLEN-1:0] : {rem_p0[XLEN-2:0], quo_p0[XLEN-1]};
  assign quo_nx   = {quo_p0[XLEN-2:0], q_bit};
  assign mul_val  = sel_p0 ? prod_fin[2*XLEN-1:XLEN] : prod_fin[XLEN-1:0];
  assign div_val  = neg_if(sel_p0 ? rem_nx : quo_nx, neg_p0);
  assign calc_val = fit_word(is_div_p0 ? div_val : mul_val, narrow_p0);

  // Stage p0: operand latch while idle, one iteration per cycle in CALC
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      is_div_p0 <= func3[2];
      sel_p0    <= func3[2] ? func3[1] : (func3[1:0] != 2'b00);
      narrow_p0 <= is_word;
      neg_p0    <= (func3[2] & func3[1]) ? neg1 : (neg1 ^ neg2);
      prod_p0   <= '0;
      mcand_p0  <= {{XLEN{1'b0}}, mag1};
      mplier_p0 <= mag2;
      rem_p0    <= '0;
      quo_p0    <= word_eff ? (mag1 << HW) : mag1;
      dvsr_p0   <= mag2;
    end else if (state == CALC) begin
      prod_p0   <= prod_nx;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
      rem_p0    <= rem_nx;
      quo_p0    <= quo_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (special) begin
            result <= fit_word(spec_val, is_word);
            state  <= DONE;
          end else begin
            cnt   <= word_eff ? CW'(HW - 1) : CW'(XLEN - 1);
            state <= CALC;
          end
        end
        CALC: if (cnt == '0) begin
          result <= calc_val;
          state  <= DONE;
        end else begin
          cnt <= cnt - CW'(1);
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC) | (state == DONE);

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: directed corner cases plus randomized ops checked against
// an arithmetic reference model.
module tb_mdu_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, is_word, flush, out_valid, out_ready, busy;
  logic [2:0]  func3;
  logic [63:0] src1, src2, result;
  int          n_chk = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mdu_seq #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .func3(func3),
    .is_word(is_word), .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void ref_mdu(input logic [2:0] f3, input logic w, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] r, output logic spec);
    logic [63:0]         ua, ub;
    logic signed [63:0]  sa, sb;
    logic signed [129:0] x, y, p;
    logic                is_min;
    ua = w ? {32'h0, a[31:0]} : a;
    ub = w ? {32'h0, b[31:0]} : b;
    sa = w ? {{32{a[31]}}, a[31:0]} : a;
    sb = w ? {{32{b[31]}}, b[31:0]} : b;
    is_min = w ? (sa == 64'shFFFF_FFFF_8000_0000) : (sa == 64'sh8000_0000_0000_0000);
    spec = 1'b0;
    r = '0;
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b011: begin
        if (f3 == 3'b011) x = $signed({66'd0, ua}); else x = sa;
        if (f3[1]) y = $signed({66'd0, ub}); else y = sb;
        p = x * y;
        r = (f3 == 3'b000) ? p[63:0] : p[127:64];
      end
      3'b100, 3'b110: begin
        if (sb == 0) begin
          spec = 1'b1;
          r = f3[1] ? sa : '1;
        end else if (is_min && sb == -1) begin
          spec = 1'b1;
          r = f3[1] ? 64'd0 : sa;
        end else begin
          r = f3[1] ? sa % sb : sa / sb;
        end
      end
      default: begin
        if (ub == 0) begin
          spec = 1'b1;
          r = f3[1] ? ua : '1;
        end else begin
          r = f3[1] ? ua % ub : ua / ub;
        end
      end
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
  endfunction

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 20));
      4: return 64'h0000_0000_8000_0000;
      5: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issues one op, waits for out_valid (bounded), holds out_ready low for
  // 'hold' cycles, then completes the handshake; returns with the DUT idle.
  task automatic do_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input int hold, output logic [63:0] res,
                       output int lat, output int nbusy, output int unstable);
    in_valid = 1'b1; func3 = f3; is_word = w; src1 = a; src2 = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'($urandom); func3 = 3'($urandom); is_word = 1'($urandom);
    src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
    lat = 1;
    nbusy = int'(busy);
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      nbusy += int'(busy);
    end
    chk_val("done", 64'(out_valid), 64'd1);
    res = result;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (result !== res || out_valid !== 1'b1 || in_ready !== 1'b0) unstable++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] r, exp_r;
    logic        spec, w;
    logic [2:0]  f3;
    logic [63:0] a, b;
    int          lat, nb, ub, seen, exp_lat;

    rst = 1'b1; in_valid = 1'b0; func3 = '0; is_word = 1'b0; src1 = '0; src2 = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_in_ready", 64'(in_ready), 64'd1);
    chk_val("rst_out_valid", 64'(out_valid), 64'd0);
    chk_val("rst_busy", 64'(busy), 64'd0);
    chk_val("rst_result", result, 64'd0);
    rst = 1'b0;

    do_op(3'b000, 1'b0, 64'd3, -64'd5, 0, r, lat, nb, ub);
    chk_val("mul_res", r, 64'hFFFF_FFFF_FFFF_FFF1);
    chk_val("mul_lat", 64'(lat), 64'd65);
    chk_val("mul_busy", 64'(nb), 64'd65);
    chk_val("mul_idle", {62'd0, busy, in_ready}, 64'd1);

    do_op(3'b011, 1'b0, '1, '1, 0, r, lat, nb, ub);
    chk_val("mulhu_res", r, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op(3'b001, 1'b0, '1, '1, 0, r, lat, nb, ub);
    chk_val("mulh_res", r, 64'h0);

    do_op(3'b101, 1'b0, 64'd100, 64'd0, 0, r, lat, nb, ub);
    chk_val("divu0_res", r, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_val("divu0_lat", 64'(lat), 64'd1);
    do_op(3'b111, 1'b0, 64'd100, 64'd0, 0, r, lat, nb, ub);
    chk_val("remu0_res", r, 64'd100);
    do_op(3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0, r, lat, nb, ub);
    chk_val("divw_ovf", r, 64'hFFFF_FFFF_8000_0000);
    chk_val("divw_ovf_lat", 64'(lat), 64'd1);
    do_op(3'b110, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0, r, lat, nb, ub);
    chk_val("remw_ovf", r, 64'd0);

    do_op(3'b100, 1'b0, -64'd7, 64'd2, 0, r, lat, nb, ub);
    chk_val("div_res", r, 64'hFFFF_FFFF_FFFF_FFFD);
    chk_val("div_lat", 64'(lat), 64'd65);
    do_op(3'b110, 1'b0, -64'd7, 64'd2, 0, r, lat, nb, ub);
    chk_val("rem_res", r, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op(3'b101, 1'b1, 64'hFFFF_FFFF, 64'd1, 0, r, lat, nb, ub);
    chk_val("divuw_res", r, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_val("divuw_lat", 64'(lat), 64'd33);

    // back-pressure, then an op accepted right after the handshake
    do_op(3'b101, 1'b0, 64'd50, 64'd7, 10, r, lat, nb, ub);
    chk_val("bp_res", r, 64'd7);
    chk_val("bp_stable", 64'(ub), 64'd0);
    chk_val("bp_idle", {62'd0, out_valid, in_ready}, 64'd1);
    do_op(3'b111, 1'b0, 64'd50, 64'd7, 0, r, lat, nb, ub);
    chk_val("bp_next", r, 64'd1);

    // flush in the middle of a divide
    in_valid = 1'b1; func3 = 3'b100; is_word = 1'b0; src1 = 64'd1000; src2 = 64'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk_val("flush_idle", {61'd0, in_ready, busy, out_valid}, 64'd4);
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk_val("flush_no_valid", 64'(seen), 64'd0);
    do_op(3'b100, 1'b0, 64'd1000, 64'd3, 0, r, lat, nb, ub);
    chk_val("flush_next", r, 64'd333);

    // flush together with a request in IDLE: not accepted
    in_valid = 1'b1; flush = 1'b1; func3 = 3'b000; src1 = 64'd2; src2 = 64'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk_val("flush_noacc", {62'd0, busy, in_ready}, 64'd1);

    // reset mid-CALC
    in_valid = 1'b1; func3 = 3'b000; is_word = 1'b0; src1 = 64'd7; src2 = 64'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_val("rst_mid", {result[61:0], in_ready, out_valid}, 64'd2);
    chk_val("rst_mid_busy", 64'(busy), 64'd0);
    do_op(3'b000, 1'b0, 64'd7, 64'd9, 0, r, lat, nb, ub);
    chk_val("rst_next", r, 64'd63);

    for (int i = 0; i < 120; i++) begin
      f3 = 3'($urandom);
      w = 1'($urandom);
      a = rnd_opnd();
      b = rnd_opnd();
      ref_mdu(f3, w, a, b, exp_r, spec);
      exp_lat = spec ? 1 : ((w && (f3 == 3'b000 || f3[2])) ? 33 : 65);
      do_op(f3, w, a, b, $urandom_range(0, 3), r, lat, nb, ub);
      if (!(w && f3 inside {3'b001, 3'b010, 3'b011})) begin
        chk_val($sformatf("rnd%0d_f%0d_w%0d_res", i, f3, w), r, exp_r);
        chk_val($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_lat));
      end
      chk_val($sformatf("rnd%0d_stable", i), 64'(ub), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
